// File: rtl/regfile.sv
// regfile: architectural integer register file for the 5-stage RV32I pipeline.
// One write-back port and two combinational read ports with same-cycle
// write-to-read bypass, plus a 64-bit count of committed register writes.
// x0 is not stored and always reads zero.
module regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [63:0]       wcount
);

  // Storage for x1..x(NREGS-1); x0 is hardwired and has no flops.
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [63:0]       wcount_q;
  logic [63:0]       wcount_d;
  logic              commit;

  // A write commits only outside reset and never to x0.
  assign commit   = we && !rst && (waddr != '0);
  assign wcount_d = wcount_q + 64'd1;

  // Register array update: reset clears every register, otherwise commit the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Committed-write counter; wraps naturally modulo 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcount_q <= '0;
    end else if (commit) begin
      wcount_q <= wcount_d;
    end
  end

  // Read port 1: reset, x0 and disabled reads force zero; a concurrent write bypasses storage.
  always_comb begin
    rdata1 = '0;
    if (rst || (raddr1 == '0) || !re1) begin
      rdata1 = '0;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_q[raddr1];
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    rdata2 = '0;
    if (rst || (raddr2 == '0) || !re2) begin
      rdata2 = '0;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

  assign wcount = wcount_q;

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file for the 5-stage RV32I pipeline. It receives the write-back port driven by the MEM/WB pipeline register (`we`/`waddr`/`wdata`) and serves two read ports to the ID stage. Same-cycle write-to-read bypass resolves the WB→ID hazard, so ID never needs a stall for a register being written back. It also keeps a 64-bit count of committed register writes for performance and debug visibility.

## Interface
Parameters:
- `ADDR_W`, 5: register address width (`RegAddrBus`)
- `DATA_W`, 32: register data width (`RegBus`)
- `NREGS`, 32: number of architectural registers, x0..x31

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset: synchronous, active-high
- `we`  in  1  write enable from the write-back stage
- `waddr`  in  ADDR_W  write destination register
- `wdata`  in  DATA_W  write data
- `re1`  in  1  read enable, port 1 (rs1)
- `raddr1`  in  ADDR_W  read address, port 1
- `rdata1`  out  DATA_W  read data, port 1 (combinational)
- `re2`  in  1  read enable, port 2 (rs2)
- `raddr2`  in  ADDR_W  read address, port 2
- `rdata2`  out  DATA_W  read data, port 2 (combinational)
- `wcount`  out  64  number of committed writes since reset (registered)

## Operation
- Storage is x1..x31, each DATA_W bits. x0 is not stored and always reads 0.
- Write: at a rising edge with `rst`=0, `we`=1 and `waddr`≠0, set `regs[waddr]` to `wdata`.
- A write with `waddr`=0 is discarded and is not counted.
- Read priority per port n, evaluated combinationally, first match wins:
  1. `rst`=1 → 0
  2. `raddrn`=0 → 0
  3. `ren`=0 → 0
  4. `we`=1 and `waddr`=`raddrn` → `wdata` (bypass)
  5. otherwise → `regs[raddrn]`
- Both ports are independent. The same address on both ports returns identical data, including identical bypassed data.
- Counter: at a rising edge with `rst`=0, `we`=1 and `waddr`≠0, `wcount` increments by 1. It wraps modulo 2^64.
- Reset: at a rising edge with `rst`=1:
  - x1..x31 clear to 0.
  - `wcount` clears to 0.
  - A write presented in the same cycle is ignored.

## Timing
- Reset values: `rdata1`=`rdata2`=0 while `rst`=1. After the reset edge, every register reads 0 and `wcount`=0.
- Write latency: 1 cycle to storage. Read-after-write latency seen at the read ports is 0 cycles, because the bypass covers the write cycle.
- Read ports have no clocked latency: output follows address, enable and bypass inputs within the same cycle.
- `wcount` updates on the same edge that commits the write and is visible the following cycle.
- Reset mid-operation: `rst` taking priority at the edge fully discards any in-flight write and any counter increment.
- X-safety: with `re`=0 or `rst`=1, the output is 0 regardless of `raddr`.

## Test plan
- Reset clear: write 0xDEADBEEF to x5, then assert `rst` for 1 cycle, deassert, read x5 → `rdata1`=0 and `wcount`=0.
- x0 hardwire: `we`=1, `waddr`=0, `wdata`=0xFFFFFFFF, with port 1 reading x0 in the same cycle and the next cycle → 0 both cycles, `wcount` unchanged.
- Write then read: write 0x12345678 to x10 in cycle N. In cycle N+1, read x10 on both ports with `we`=0 → both ports 0x12345678. `wcount` increments by 1.
- Bypass: x7 holds 0x1. In one cycle drive `we`=1, `waddr`=7, `wdata`=0xA5A5A5A5 with `raddr1`=7, `raddr2`=8 → `rdata1`=0xA5A5A5A5 in that cycle, `rdata2`=old x8.
- Read enable gating: x3 holds 0x55. Read with `re2`=0, `raddr2`=3 → `rdata2`=0. Set `re2`=1 → 0x55.
- Counter and reset priority: 31 back-to-back writes to x1..x31 give `wcount`=31. Then `rst`=1 together with `we`=1 to x4 gives x4=0 and `wcount`=0 afterward.
